// File: rtl/urish_sic1.sv
// -----------------------------------------------------------------------------
// urish_sic1 -- SIC-1 single-instruction (subleq) 8-bit CPU as a TinyTapeout
// user tile.
//
// A 32-byte program/data RAM is loaded byte-serially over the tile pins while
// run=0. With run=1 the core executes subleq instructions (A, B, C):
//   mem[A] = mem[A] - mem[B]; if result <= 0 (signed) jump to C, else pc += 3
// until the program counter lands on @HALT (253..255 end execution).
//
// Memory map (8-bit address space, RAM mirrored every 32 bytes):
//   253 @IN   : reads ui_in, writes discarded
//   254 @OUT  : reads 0, writes update uo_out
//   255 @HALT : reads 0, writes discarded
//
// Ports:
//   clk      : single clock for all state
//   rst_n    : asynchronous active-low reset (clears RAM as well)
//   ena      : tile enable, ignored
//   ui_in    : load byte in program mode, @IN value in run mode
//   uo_out   : registered @OUT value
//   uio_in   : [0] run, [1] load_we, [2] load_ptr_clr, [7:3] ignored
//   uio_out  : [7] in_strobe, [6] halted, [5] out_strobe, [4:0] zero
//   uio_oe   : constant 8'hE0 (upper three uio pins are outputs)
// -----------------------------------------------------------------------------
module urish_sic1 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [7:0] ADDR_IN   = 8'd253;
    localparam logic [7:0] ADDR_OUT  = 8'd254;
    localparam logic [7:0] ADDR_HALT = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_e;

    state_e state_q, state_d;

    logic [7:0]       pc_q, pc_d;
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;
    logic [7:0]       c_q, c_d;
    logic [7:0]       out_q, out_d;
    logic [4:0]       load_ptr_q, load_ptr_d;
    logic [31:0][7:0] ram_q;

    logic       ram_we;
    logic [4:0] ram_waddr;
    logic [7:0] ram_wdata;

    logic run;
    logic load_we;
    logic load_clr;

    logic [7:0] pc_p1, pc_p2, pc_seq, pc_exec;
    logic [7:0] op_a, op_b, res;
    logic       take, exec_halt;

    logic in_strobe, out_strobe, halted;

    // Tile enable and spare control bits are intentionally unused.
    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[7:3]};

    assign run      = uio_in[0];
    assign load_we  = uio_in[1];
    assign load_clr = uio_in[2];

    // Read decode shared by fetch and operand reads.
    function automatic logic [7:0] rd_mem(input logic [7:0]       addr,
                                          input logic [31:0][7:0] mem,
                                          input logic [7:0]       in_val);
        logic [7:0] val;
        if (addr == ADDR_IN) begin
            val = in_val;
        end else if (addr == ADDR_OUT || addr == ADDR_HALT) begin
            val = '0;
        end else begin
            val = mem[addr[4:0]];
        end
        return val;
    endfunction

    // ------------------------------------------------------------------
    // Execute datapath
    // ------------------------------------------------------------------
    always_comb begin
        pc_p1     = pc_q + 8'd1;
        pc_p2     = pc_q + 8'd2;
        pc_seq    = pc_q + 8'd3;
        op_a      = rd_mem(a_q, ram_q, ui_in);
        op_b      = rd_mem(b_q, ram_q, ui_in);
        res       = op_a - op_b;
        // Branch when the signed result is zero or negative.
        take      = (res == '0) || res[7];
        pc_exec   = take ? c_q : pc_seq;
        exec_halt = (pc_exec >= ADDR_IN);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic (run=0 always returns to IDLE)
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (!run) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  state_d = ST_FETCH;
                ST_FETCH: state_d = ST_EXEC;
                ST_EXEC:  state_d = exec_halt ? ST_HALT : ST_FETCH;
                ST_HALT:  state_d = ST_HALT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath next-state: load port, fetch latches, writeback
    // ------------------------------------------------------------------
    always_comb begin
        pc_d       = pc_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        out_d      = out_q;
        load_ptr_d = load_ptr_q;
        ram_we     = 1'b0;
        ram_waddr  = '0;
        ram_wdata  = '0;

        if (!run) begin
            // Program mode; a pending EXEC writeback is dropped here.
            pc_d = '0;
            if (load_clr) begin
                load_ptr_d = '0;
            end else if (load_we) begin
                ram_we     = 1'b1;
                ram_waddr  = load_ptr_q;
                ram_wdata  = ui_in;
                load_ptr_d = load_ptr_q + 5'd1;
            end
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    a_d = rd_mem(pc_q,  ram_q, ui_in);
                    b_d = rd_mem(pc_p1, ram_q, ui_in);
                    c_d = rd_mem(pc_p2, ram_q, ui_in);
                end
                ST_EXEC: begin
                    pc_d = pc_exec;
                    if (a_q == ADDR_OUT) begin
                        out_d = res;
                    end else if (a_q != ADDR_IN && a_q != ADDR_HALT) begin
                        ram_we    = 1'b1;
                        ram_waddr = a_q[4:0];
                        ram_wdata = res;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            out_q      <= '0;
            load_ptr_q <= '0;
            ram_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            out_q      <= out_d;
            load_ptr_q <= load_ptr_d;
            if (ram_we) begin
                ram_q[ram_waddr] <= ram_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (gated by run so program mode always reads quiet)
    // ------------------------------------------------------------------
    always_comb begin
        halted     = run && (state_q == ST_HALT);
        in_strobe  = run && (state_q == ST_EXEC) &&
                     ((a_q == ADDR_IN) || (b_q == ADDR_IN));
        out_strobe = run && (state_q == ST_EXEC) && (a_q == ADDR_OUT);
    end

    assign uo_out  = out_q;
    assign uio_out = {in_strobe, halted, out_strobe, 5'b00000};
    assign uio_oe  = 8'hE0;

endmodule

// File: tb/tb_urish_sic1.sv
// -----------------------------------------------------------------------------
// Testbench for urish_sic1. Stimulus loads small subleq programs and pushes the
// expected @OUT values into a queue; an independent monitor pops and compares
// one entry each time the DUT signals an @OUT write (out_strobe), sampling
// uo_out on the falling edge after the write has landed.
// -----------------------------------------------------------------------------
module tb_urish_sic1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    urish_sic1 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] prog_q[$];
    int         in_cnt  = 0;
    int         out_cnt = 0;
    logic       halt_seen = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Monitor: an out_strobe seen on one falling edge means uo_out is valid
    // on the next falling edge.
    initial begin
        logic       prev_out;
        logic [7:0] e;
        prev_out = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_out = 1'b0;
            end else begin
                if (prev_out) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL uo_out unexpected write: got %02h expected none", uo_out);
                    end else begin
                        e = exp_q.pop_front();
                        if (uo_out !== e) begin
                            bad++;
                            $display("FAIL uo_out scoreboard: got %02h expected %02h", uo_out, e);
                        end
                    end
                end
                prev_out = uio_out[5];
                if (uio_out[7] === 1'b1) in_cnt++;
                if (uio_out[5] === 1'b1) out_cnt++;
                if (uio_out[6] === 1'b1) halt_seen = 1'b1;
            end
        end
    end

    task automatic load_prog();
        @(negedge clk);
        uio_in = 8'b0000_0100;
        foreach (prog_q[i]) begin
            @(negedge clk);
            uio_in = 8'b0000_0010;
            ui_in  = prog_q[i];
        end
        @(negedge clk);
        uio_in = 8'b0000_0000;
    endtask

    task automatic start_run();
        @(negedge clk);
        uio_in = 8'b0000_0001;
    endtask

    task automatic stop_run(input string name);
        @(negedge clk);
        uio_in = 8'b0000_0000;
        @(negedge clk);
        #1;
        chk(name, {7'd0, uio_out[6]}, 8'd0);
    endtask

    task automatic wait_halt(input string name);
        int n;
        n = 0;
        while (uio_out[6] !== 1'b1 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, {7'd0, uio_out[6]}, 8'd1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, 8'(exp_q.size()), 8'd0);
        exp_q.delete();
    endtask

    initial begin
        int oc;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #12;
        chk("reset uo_out", uo_out, 8'h00);
        chk("reset uio_oe", uio_oe, 8'hE0);
        chk("reset uio_out", uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // 0 - RAM[6](=5) -> @OUT = FB, negative so jump to 255 and halt.
        prog_q = '{8'd254, 8'd6, 8'd255, 8'd0, 8'd0, 8'd0, 8'd5};
        load_prog();
        in_cnt  = 0;
        out_cnt = 0;
        exp_q.push_back(8'hFB);
        start_run();
        wait_halt("t1 halt");
        wait_drain("t1 out drained");
        chk("t1 out strobe count", 8'(out_cnt), 8'd1);
        repeat (10) @(negedge clk);
        #1;
        chk("t1 halted holds", {7'd0, uio_out[6]}, 8'd1);
        chk("t1 no extra strobes", 8'(out_cnt), 8'd1);
        chk("t1 uo_out held", uo_out, 8'hFB);
        stop_run("t1 halted clears");

        // RAM[10]=7-3=4, positive -> fall through to 3; peek gives 0-4 = FC.
        prog_q = '{8'd10, 8'd11, 8'd20, 8'd254, 8'd10, 8'd255,
                   8'd0, 8'd0, 8'd0, 8'd0, 8'd7, 8'd3};
        load_prog();
        exp_q.push_back(8'hFC);
        start_run();
        wait_halt("t2 halt");
        wait_drain("t2 out drained");
        stop_run("t2 halted clears");

        // 80 - 01 = 7F (positive, no branch); peek gives 0-7F = 81.
        prog_q = '{8'd10, 8'd11, 8'd20, 8'd254, 8'd10, 8'd255,
                   8'd0, 8'd0, 8'd0, 8'd0, 8'h80, 8'h01};
        load_prog();
        exp_q.push_back(8'h81);
        start_run();
        wait_halt("t3 halt");
        wait_drain("t3 out drained");
        stop_run("t3 halted clears");

        // 33 - 33 = 0 -> branch to 6; peek of RAM[10]=0 gives 00.
        prog_q = '{8'd10, 8'd11, 8'd6, 8'd255, 8'd255, 8'd255,
                   8'd254, 8'd10, 8'd255, 8'd0, 8'h33, 8'h33};
        load_prog();
        exp_q.push_back(8'h00);
        start_run();
        wait_halt("t4 halt");
        wait_drain("t4 out drained");
        stop_run("t4 halted clears");

        // Echo loop: @OUT = 0 - (0 - @IN) = @IN.
        prog_q = '{8'd10, 8'd10, 8'd3, 8'd10, 8'd253, 8'd6,
                   8'd254, 8'd10, 8'd9, 8'd12, 8'd12, 8'd0, 8'd0};
        load_prog();
        ui_in     = 8'h2A;
        in_cnt    = 0;
        out_cnt   = 0;
        halt_seen = 1'b0;
        repeat (3) exp_q.push_back(8'h2A);
        start_run();
        wait_drain("echo 2A drained");
        chk("echo in strobes", 8'(in_cnt), 8'd3);
        chk("echo out strobes", 8'(out_cnt), 8'd3);
        ui_in = 8'h81;
        repeat (2) exp_q.push_back(8'h81);
        wait_drain("echo 81 drained");
        chk("echo in strobes 2", 8'(in_cnt), 8'd5);
        chk("echo never halts", {7'd0, halt_seen}, 8'd0);

        stop_run("drop halted low");
        oc = out_cnt;
        repeat (5) @(negedge clk);
        #1;
        chk("drop uo_out retained", uo_out, 8'h81);
        chk("drop no writes", 8'(out_cnt - oc), 8'd0);
        exp_q.push_back(8'h81);
        start_run();
        wait_drain("rerun repeats output");

        // Asynchronous reset mid-run, between clock edges.
        repeat (3) @(negedge clk);
        #3;
        rst_n  = 1'b0;
        uio_in = 8'h00;
        #1;
        chk("midrun reset uo_out", uo_out, 8'h00);
        chk("midrun reset uio_out", uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // RAM[4] held 253 before reset; cleared RAM gives 0 - 0 = 00.
        prog_q = '{8'd254, 8'd4, 8'd255};
        load_prog();
        exp_q.push_back(8'h00);
        start_run();
        wait_halt("post-reset peek halt");
        wait_drain("post-reset RAM cleared");
        stop_run("post-reset halted clears");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
